// File: rtl/multi_channel_edge_pulse_synchronizer.sv
// rtl/multi_channel_edge_pulse_synchronizer.sv - per-channel CDC synchronizer, glitch filter and edge-to-pulse with sticky flags
module multi_channel_edge_pulse_synchronizer #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_CH-1:0]     i_level_data,
    input  logic [2*NUM_CH-1:0]   i_edge_mode,
    input  logic [NUM_CH-1:0]     i_sticky_clr,
    output logic [NUM_CH-1:0]     o_pulse_data,
    output logic [NUM_CH-1:0]     o_level_sync,
    output logic [NUM_CH-1:0]     o_sticky
);

    localparam int CNT_W = $clog2(FILT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    genvar ch;
    generate
        for (ch = 0; ch < NUM_CH; ch++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic [CNT_W-1:0]       r_cnt;
            logic                   r_filt;
            logic                   r_filt_prev;
            logic                   r_pulse;
            logic                   r_sticky;
            logic                   w_synced;
            logic                   w_rise;
            logic                   w_fall;
            logic                   w_pulse_next;
            logic                   w_sticky_next;

            assign w_synced = r_sync[SYNC_STAGES-1];

            always_comb begin
                w_rise        = 1'b0;
                w_fall        = 1'b0;
                w_pulse_next  = 1'b0;
                w_sticky_next = 1'b0;
                w_rise        = r_filt & ~r_filt_prev;
                w_fall        = ~r_filt & r_filt_prev;
                w_pulse_next  = (i_edge_mode[2*ch] & w_rise) | (i_edge_mode[2*ch+1] & w_fall);
                // A new pulse beats a simultaneous clear so no event is lost.
                w_sticky_next = (r_sticky & ~i_sticky_clr[ch]) | w_pulse_next;
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_sync      <= '0;
                    r_cnt       <= '0;
                    r_filt      <= 1'b0;
                    r_filt_prev <= 1'b0;
                    r_pulse     <= 1'b0;
                    r_sticky    <= 1'b0;
                end else begin
                    r_sync      <= {r_sync[SYNC_STAGES-2:0], i_level_data[ch]};
                    // A level must persist FILT_CYCLES consecutive cycles; any return restarts the count.
                    if (w_synced == r_filt) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_filt <= w_synced;
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                    r_filt_prev <= r_filt;
                    r_pulse     <= w_pulse_next;
                    r_sticky    <= w_sticky_next;
                end
            end

            assign o_pulse_data[ch] = r_pulse;
            assign o_level_sync[ch] = r_filt;
            assign o_sticky[ch]     = r_sticky;
        end
    endgenerate

endmodule

// File: tb/tb_multi_channel_edge_pulse_synchronizer.sv
// tb/tb_multi_channel_edge_pulse_synchronizer.sv - self-checking bench, filter-off and 4-cycle-filter instances
module tb_multi_channel_edge_pulse_synchronizer;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] lvl;
    logic [3:0] clr;
    logic [7:0] mode;
    logic [3:0] p0, l0, s0, p1, l1, s1;

    int    checks   = 0;
    int    failures = 0;
    bit    mon_en   = 1'b0;
    string cur_test = "init";

    always #5 clk = ~clk;

    multi_channel_edge_pulse_synchronizer #(.NUM_CH(4), .SYNC_STAGES(2), .FILT_CYCLES(1)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_level_data(lvl), .i_edge_mode(mode), .i_sticky_clr(clr),
        .o_pulse_data(p0), .o_level_sync(l0), .o_sticky(s0));

    multi_channel_edge_pulse_synchronizer #(.NUM_CH(4), .SYNC_STAGES(2), .FILT_CYCLES(4)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_level_data(lvl), .i_edge_mode(mode), .i_sticky_clr(clr),
        .o_pulse_data(p1), .o_level_sync(l1), .o_sticky(s1));

    // Reference model: input history, synced history, and a window rule for the filter.
    bit m_in[2][4][8];
    bit m_sy[2][4][8];
    bit m_f[2][4], m_fp[2][4], m_p[2][4], m_s[2][4];

    function automatic int filt_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    always @(posedge clk) begin
        bit np, acc;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 4; c++) begin
                if (rst) begin
                    for (int j = 0; j < 8; j++) begin
                        m_in[i][c][j] <= 1'b0;
                        m_sy[i][c][j] <= 1'b0;
                    end
                    m_f[i][c] <= 1'b0; m_fp[i][c] <= 1'b0;
                    m_p[i][c] <= 1'b0; m_s[i][c]  <= 1'b0;
                end else begin
                    np = (mode[2*c] & m_f[i][c] & ~m_fp[i][c]) | (mode[2*c+1] & ~m_f[i][c] & m_fp[i][c]);
                    acc = 1'b1;
                    for (int j = 0; j < filt_of(i); j++)
                        if (m_sy[i][c][j] == m_f[i][c]) acc = 1'b0;
                    m_p[i][c]  <= np;
                    m_s[i][c]  <= (m_s[i][c] & ~clr[c]) | np;
                    m_fp[i][c] <= m_f[i][c];
                    m_f[i][c]  <= m_f[i][c] ^ acc;
                    for (int j = 1; j < 8; j++) begin
                        m_in[i][c][j] <= m_in[i][c][j-1];
                        m_sy[i][c][j] <= m_sy[i][c][j-1];
                    end
                    m_in[i][c][0] <= lvl[c];
                    m_sy[i][c][0] <= m_in[i][c][S-2];
                end
            end
        end
    end

    function automatic logic [23:0] model_vec();
        logic [23:0] v;
        for (int c = 0; c < 4; c++) begin
            v[c]      = m_s[0][c]; v[4+c]  = m_f[0][c]; v[8+c]  = m_p[0][c];
            v[12+c]   = m_s[1][c]; v[16+c] = m_f[1][c]; v[20+c] = m_p[1][c];
        end
        return v;
    endfunction

    wire [23:0] dut_vec = {p1, l1, s1, p0, l0, s0};

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL model_%s t=%0t actual=%h required=%h", cur_test, $time, dut_vec, model_vec());
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b1; lvl = '0; clr = '0; mode = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        cur_test = "reset";
        rst = 1'b1; lvl = 4'hF; clr = '0; mode = 8'hFF;
        @(negedge clk);
        mon_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== 24'h0) begin
                failures++;
                $display("FAIL reset_outputs actual=%h required=%h", dut_vec, 24'h0);
            end
        end
        apply_reset();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_rise_latency();
        cur_test = "rise";
        apply_reset();
        mode = 8'b0000_0001; lvl = 4'b0001;
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            checks++;
            if ({p0[0], l0[0], s0[0]} !== {e == 4, e >= 3, e >= 4}) begin
                failures++;
                $display("FAIL rise_latency edge=%0d actual(p,l,s)=%b%b%b required=%b%b%b",
                         e, p0[0], l0[0], s0[0], e == 4, e >= 3, e >= 4);
            end
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_toggle_modes();
        int mds[3] = '{3, 2, 0};
        logic [63:0] pm0, pm1, exp0, exp1;
        bit lseen;
        cur_test = "toggle";
        foreach (mds[k]) begin
            apply_reset();
            mode = {6'b0, 2'(mds[k])}; lvl = 4'b0001;
            pm0 = '0; pm1 = '0; lseen = 1'b0;
            for (int t = 1; t <= 40; t++) begin
                @(negedge clk);
                if (p0[0]) pm0[t] = 1'b1;
                if (p1[0]) pm1[t] = 1'b1;
                if (l0[0] && l1[0]) lseen = 1'b1;
                if (t == 10) lvl = 4'b0000;
            end
            exp0 = '0; exp1 = '0;
            if (mds[k] & 1) begin exp0[4]  = 1'b1; exp1[7]  = 1'b1; end
            if (mds[k] & 2) begin exp0[14] = 1'b1; exp1[17] = 1'b1; end
            checks++;
            if (pm0 !== exp0 || pm1 !== exp1) begin
                failures++;
                $display("FAIL toggle_mode%0d actual=%h/%h required=%h/%h", mds[k], pm0, pm1, exp0, exp1);
            end
            checks++;
            if (lseen !== 1'b1) begin
                failures++;
                $display("FAIL toggle_level_follow mode%0d actual=%b required=1", mds[k], lseen);
            end
        end
    endtask

    task automatic test_glitch_filter();
        logic [63:0] pm1, lm1, exp_p, exp_l;
        cur_test = "glitch";
        for (int w = 3; w <= 4; w++) begin
            apply_reset();
            mode = 8'b0000_0001; lvl = 4'b0001;
            pm1 = '0; lm1 = '0;
            for (int t = 1; t <= 20; t++) begin
                @(negedge clk);
                if (p1[0]) pm1[t] = 1'b1;
                if (l1[0]) lm1[t] = 1'b1;
                if (t == w) lvl = 4'b0000;
            end
            exp_p = '0; exp_l = '0;
            if (w == 4) begin
                exp_p[S+5] = 1'b1;
                exp_l[9:6] = 4'hF;
            end
            checks++;
            if (pm1 !== exp_p || lm1 !== exp_l) begin
                failures++;
                $display("FAIL glitch_w%0d actual(p,l)=%h,%h required=%h,%h", w, pm1, lm1, exp_p, exp_l);
            end
        end
    endtask

    task automatic test_multi_channel();
        logic [63:0] pm[4], ex[4];
        int r;
        cur_test = "multi";
        apply_reset();
        r = int'($urandom_range(0, 3));
        for (int c = 0; c < 4; c++) begin
            mode[2*c +: 2] = 2'((c + r) % 4);
            pm[c] = '0;
        end
        for (int t = 1; t <= 45; t++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (p0[c]) pm[c][t] = 1'b1;
                if (t == 2 + 3*c)  lvl[c] = 1'b1;
                if (t == 20 + 3*c) lvl[c] = 1'b0;
            end
        end
        for (int c = 0; c < 4; c++) begin
            ex[c] = '0;
            if (mode[2*c])   ex[c][2 + 3*c + 4]  = 1'b1;
            if (mode[2*c+1]) ex[c][20 + 3*c + 4] = 1'b1;
            checks++;
            if (pm[c] !== ex[c]) begin
                failures++;
                $display("FAIL multi_ch%0d actual=%h required=%h", c, pm[c], ex[c]);
            end
        end
    endtask

    task automatic test_sticky_clr();
        cur_test = "sticky";
        apply_reset();
        mode = 8'b0000_1100; lvl = 4'b0010;
        for (int t = 1; t <= 24; t++) begin
            @(negedge clk);
            if (t == 14) begin
                checks++;
                if ({p0[1], s0[1]} !== 2'b11) begin
                    failures++;
                    $display("FAIL sticky_set_beats_clr actual(p,s)=%b%b required=11", p0[1], s0[1]);
                end
            end
            if (t == 20 || t == 21) begin
                checks++;
                if (s0[1] !== (t == 20)) begin
                    failures++;
                    $display("FAIL sticky_clear t=%0d actual=%b required=%b", t, s0[1], t == 20);
                end
            end
            if (t == 10) lvl[1] = 1'b0;
            if (t == 13 || t == 20) clr[1] = 1'b1;
            if (t == 14 || t == 21) clr[1] = 1'b0;
        end
    endtask

    task automatic test_reset_mid_filter();
        logic [63:0] pm0, pm1, exp0, exp1;
        cur_test = "rst_mid";
        apply_reset();
        mode = 8'h55; lvl = 4'b0100;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== 24'h0) begin
                failures++;
                $display("FAIL rst_mid_outputs actual=%h required=%h", dut_vec, 24'h0);
            end
        end
        rst = 1'b0;
        pm0 = '0; pm1 = '0;
        for (int t = 1; t <= 14; t++) begin
            @(negedge clk);
            if (p0[2]) pm0[t] = 1'b1;
            if (p1[2]) pm1[t] = 1'b1;
        end
        exp0 = 64'd1 << 4; exp1 = 64'd1 << 7;
        checks++;
        if (pm0 !== exp0 || pm1 !== exp1) begin
            failures++;
            $display("FAIL rst_mid_pulse actual=%h/%h required=%h/%h", pm0, pm1, exp0, exp1);
        end
    endtask

    task automatic test_random();
        cur_test = "random";
        apply_reset();
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 5) == 0) lvl[c] = ~lvl[c];
            if ($urandom_range(0, 15) == 0) mode = 8'($urandom);
            clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            rst = ($urandom_range(0, 150) == 0);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_rise_latency();
        test_toggle_modes();
        test_glitch_filter();
        test_multi_channel();
        test_sticky_clr();
        test_reset_mid_filter();
        test_random();
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
